dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate data-cache controller between the memory stage and the

---
 rtl/dcache_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Miss path: optional 4-word write-back, then 4-word allocate overlapped with the memory latency.
module dcache_ctrl #(
  parameter int TAG_W   = 5,
  parameter int IDX_W   = 8,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      Addr,
  input  logic [15:0]      DataIn,
  input  logic             Rd,
  input  logic             Wr,
  output logic [15:0]      DataOut,
  output logic             Done,
  output logic             Stall,
  output logic             CacheHit,
  output logic             err,
  output logic [3:0]       state,
  output logic             c_en,
  output logic             c_comp,
  output logic             c_write,
  output logic             c_valid_in,
  output logic [IDX_W-1:0] c_index,
  output logic [2:0]       c_offset,
  output logic [TAG_W-1:0] c_tag_in,
  output logic [15:0]      c_data_in,
  input  logic             c_hit,
  input  logic             c_dirty,
  input  logic             c_valid,
  input  logic             c_err,
  input  logic [TAG_W-1:0] c_tag_out,
  input  logic [15:0]      c_data_out,
  output logic [15:0]      m_addr,
  output logic [15:0]      m_data_in,
  output logic             m_wr,
  output logic             m_rd,
  input  logic [15:0]      m_data_out,
  input  logic             m_stall,
  input  logic             m_err
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] WB0  = 4'd1;
  localparam logic [3:0] WB3  = 4'd4;
  localparam logic [3:0] AL0  = 4'd5;
  localparam logic [3:0] AL3  = 4'd8;
  localparam logic [3:0] AL5  = 4'd10;
  localparam logic [3:0] FIN  = 4'd11;
  // First allocate state whose memory read data has arrived.
  localparam logic [3:0] WR_FIRST = 4'(AL0 + MEM_LAT);

  logic [3:0]       next_state;
  logic             latch_req;
  logic             fault;
  logic [15:0]      req_addr;
  logic [15:0]      req_data;
  logic             req_rd;
  logic             req_wr;
  logic [TAG_W-1:0] victim_tag;
  logic [TAG_W-1:0] in_tag, req_tag;
  logic [IDX_W-1:0] in_idx, req_idx;
  logic [1:0]       wb_word, rd_word, wr_word;

  assign in_tag  = Addr[15 -: TAG_W];
  assign in_idx  = Addr[IDX_W+2:3];
  assign req_tag = req_addr[15 -: TAG_W];
  assign req_idx = req_addr[IDX_W+2:3];
  assign wb_word = 2'(state - WB0);
  assign rd_word = 2'(state - AL0);
  assign wr_word = 2'(state - WR_FIRST);
  assign Stall   = !rst && (state != IDLE);

  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    Done       = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    DataOut    = '0;
    c_en       = 1'b0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    c_index    = '0;
    c_offset   = '0;
    c_tag_in   = '0;
    c_data_in  = '0;
    m_addr     = '0;
    m_data_in  = '0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    // Response faults abort without gating strobes, keeping c_err/m_err free of combinational loops.
    fault = c_err || m_err || (m_stall && state >= WB0 && state <= AL3);
    if (!rst) begin
      if (state == IDLE) begin
        if ((Rd && Wr) || ((Rd || Wr) && Addr[0])) begin
          err = 1'b1;
        end else if (Rd || Wr) begin
          c_en      = 1'b1;
          c_comp    = 1'b1;
          c_write   = Wr;
          c_index   = in_idx;
          c_offset  = Addr[2:0];
          c_tag_in  = in_tag;
          c_data_in = DataIn;
          if (c_hit && c_valid) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            if (Rd) DataOut = c_data_out;
          end else begin
            latch_req  = 1'b1;
            next_state = (c_valid && c_dirty) ? WB0 : AL0;
          end
        end
      end else if (state >= WB0 && state <= WB3) begin
        c_en       = 1'b1;
        c_index    = req_idx;
        c_offset   = {wb_word, 1'b0};
        m_wr       = 1'b1;
        m_addr     = {victim_tag, req_idx, wb_word, 1'b0};
        m_data_in  = c_data_out;
        next_state = (state == WB3) ? AL0 : state + 4'd1;
      end else if (state >= AL0 && state <= AL5) begin
        if (state <= AL3) begin
          m_rd   = 1'b1;
          m_addr = {req_tag, req_idx, rd_word, 1'b0};
        end
        if (state >= WR_FIRST) begin
          c_en       = 1'b1;
          c_write    = 1'b1;
          c_index    = req_idx;
          c_offset   = {wr_word, 1'b0};
          c_tag_in   = req_tag;
          c_data_in  = m_data_out;
          c_valid_in = (state == AL5);
        end
        next_state = (state == AL5) ? FIN : state + 4'd1;
      end else if (state == FIN) begin
        // Replay the latched request against the freshly filled line.
        c_en       = 1'b1;
        c_comp     = 1'b1;
        c_write    = req_wr;
        c_index    = req_idx;
        c_offset   = req_addr[2:0];
        c_tag_in   = req_tag;
        c_data_in  = req_data;
        Done       = 1'b1;
        if (req_rd) DataOut = c_data_out;
        next_state = IDLE;
      end else begin
        err        = 1'b1;
        next_state = IDLE;
      end
      if (fault) begin
        err        = 1'b1;
        Done       = 1'b0;
        CacheHit   = 1'b0;
        DataOut    = '0;
        latch_req  = 1'b0;
        next_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_data   <= '0;
      req_rd     <= 1'b0;
      req_wr     <= 1'b0;
      victim_tag <= '0;
    end else begin
      state <= next_state;
      if (latch_req) begin
        req_addr   <= Addr;
        req_data   <= DataIn;
        req_rd     <= Rd;
        req_wr     <= Wr;
        victim_tag <= c_tag_out;
      end
    end
  end

endmodule
